branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-bit branch encoder.
- Resolves all six RV32 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) from operand values and returns a registered taken/mispredict result.
- Holds a PC-indexed table of 2-bit saturating counters. Fetch reads it for prediction; resolution updates it.
- Keeps saturating branch and mispredict statistics counters.
- Sits between the execute-stage register-file read and the PC-select logic.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, counter-table depth; power of two, at least 2.
- IDX_W, $clog2(BHT_ENTRIES), table index width; derived, not overridden.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  resolve request this cycle
- Branch  in  1  instruction is a conditional branch
- funct3  in  3  branch condition
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B
- pc  in  XLEN  PC of the branch being resolved
- pred_taken  in  1  prediction fetch made for this branch
- flush  in  1  kill the request and the pending result
- lookup_pc  in  XLEN  fetch-side PC to predict
- lookup_taken  out  1  combinational prediction: counter[lookup_pc index][1]
- out_valid  out  1  registered result valid
- taken  out  1  branch taken
- mispredict  out  1  taken differs from pred_taken
- illegal  out  1  Branch=1 with reserved funct3
- branch_count  out  CNT_W  legal branches resolved
- mispredict_count  out  CNT_W  mispredicts

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - out_valid, taken, mispredict, illegal = 0.
  - Both statistics counters = 0.
  - Every table entry = 2'b01 (weakly not-taken), cleared in the reset cycle.
- Latency: request sampled at edge N; outputs valid from edge N until edge N+1. out_valid is a one-cycle pulse per request. No backpressure; a request may arrive every cycle.
- Index: pc[IDX_W+1:2]; the same slice of lookup_pc. Bits [1:0] are ignored.
- Condition decode (signed compares use $signed of full XLEN):
  - 000: equal
  - 001: not equal
  - 100: signed less-than
  - 101: signed greater-or-equal
  - 110: unsigned less-than
  - 111: unsigned greater-or-equal
  - 010, 011: reserved
- Accepted request: in_valid=1 and flush=0 and reset=0.
  - out_valid <= 1.
  - If Branch=0: taken/mispredict/illegal <= 0; no table or counter change.
  - If Branch=1 with reserved funct3: illegal <= 1, taken <= 0, mispredict <= 0; no table or counter change.
  - If Branch=1 with legal funct3:
    - taken <= condition.
    - mispredict <= condition XOR pred_taken.
    - Table entry updates: +1 if taken, -1 if not; saturate at 2'b11 and 2'b00.
    - branch_count increments, saturating at all-ones.
    - mispredict_count increments on mispredict, saturating at all-ones.
- No accepted request: out_valid <= 0; taken/mispredict/illegal <= 0.
- flush=1: same edge as in_valid drops the request (out_valid <= 0, no updates). A result already visible clears at the next edge as normal.
- reset has priority over flush, which has priority over in_valid.
- Same-index collision: if lookup_pc and pc map to the same index in the updating cycle, lookup_taken shows the pre-update value. The new value is visible the next cycle.
- Back-to-back branches to the same index: the second uses the counter already written by the first. No stale read.

Decomposition:
- Shared package:
  - funct3 localparams: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Counter localparams: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
- One sub-module: branch_compare (combinational XLEN comparator; outputs cond_true, legal).
- Table, update logic and statistics counters stay in the top module.

Test Plan:
- Reset, then in_valid=1, Branch=1, funct3=101, rs1=32'hFFFF_FFFF (-1), rs2=0, pred_taken=0 -> next cycle out_valid=1, taken=0, mispredict=0, branch_count=1.
- funct3=110, rs1=1, rs2=32'hFFFF_FFFF, pred_taken=0 -> taken=1, mispredict=1, mispredict_count=1. Then lookup_pc=same pc -> lookup_taken=1 (counter 01->10).
- Four taken BNE at pc=32'h100 -> counter saturates at 11. lookup_pc=32'h100 reads 0 in the update cycle only if the counter was 01; it reads 1 after. A fifth taken branch leaves the counter at 11.
- Branch=1, funct3=010 -> illegal=1, taken=0, counters unchanged. Branch=0, funct3=101 -> out_valid=1, all flags 0, counters unchanged.
- in_valid=1 with flush=1 -> out_valid stays 0, no update. Reset asserted mid-stream after 3 branches -> outputs, counts and all entries return to reset values next cycle.
- Force CNT_W=2 build; resolve 5 mispredicting branches -> branch_count and mispredict_count hold at 3.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and helpers for the branch resolve unit.
package branch_resolve_unit_pkg;

    // RV32 conditional-branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating predictor counter states
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Next counter state: step toward taken or not-taken, saturating at both ends
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic inc);
        logic [1:0] nxt;
        nxt = ctr;
        if (inc) begin
            if (ctr != CTR_ST) begin
                nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                nxt = ctr - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch-condition evaluator for the six RV32 conditional branches.
module branch_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            cond_true,
    output logic            legal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_data == rs2_data);
    assign lt_s = ($signed(rs1_data) < $signed(rs2_data));
    assign lt_u = (rs1_data < rs2_data);

    // Select the condition; reserved encodings report not-legal and never taken
    always_comb begin
        cond_true = 1'b0;
        legal     = 1'b1;
        case (funct3)
            F3_BEQ:  cond_true = eq;
            F3_BNE:  cond_true = !eq;
            F3_BLT:  cond_true = lt_s;
            F3_BGE:  cond_true = !lt_s;
            F3_BLTU: cond_true = lt_u;
            F3_BGEU: cond_true = !lt_u;
            default: legal     = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches, tracks a PC-indexed 2-bit predictor table
// and keeps saturating branch / mispredict statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             Branch,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    input  logic             pred_taken,
    input  logic             flush,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    output logic             out_valid,
    output logic             taken,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lkp_idx;
    logic             cond_true;
    logic             legal;
    logic             accept;
    logic             resolve;
    logic             mispred;

    // Word-aligned PCs: drop the byte offset, keep the low index bits
    assign upd_idx = pc[IDX_W+1:2];
    assign lkp_idx = lookup_pc[IDX_W+1:2];

    generate
        if (XLEN > IDX_W + 2) begin : g_pc_hi
            logic unused_pc_bits;
            assign unused_pc_bits = ^{pc[XLEN-1:IDX_W+2], pc[1:0],
                                      lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};
        end else begin : g_pc_lo
            logic unused_pc_bits;
            assign unused_pc_bits = ^{pc[1:0], lookup_pc[1:0]};
        end
    endgenerate

    branch_compare #(
        .XLEN(XLEN)
    ) u_compare (
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .cond_true (cond_true),
        .legal     (legal)
    );

    // flush kills the request outright; reset priority is applied in the registers
    assign accept  = in_valid && !flush;
    assign resolve = accept && Branch && legal;
    assign mispred = cond_true ^ pred_taken;

    // Fetch-side prediction reads the registered table, so a same-cycle update is not visible yet
    assign lookup_taken = bht[lkp_idx][1];

    // Result flags: one-cycle pulse per accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            taken      <= 1'b0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            out_valid  <= accept;
            taken      <= 1'b0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
            if (accept && Branch) begin
                if (legal) begin
                    taken      <= cond_true;
                    mispredict <= mispred;
                end else begin
                    illegal    <= 1'b1;
                end
            end
        end
    end

    // Predictor table: every entry back to weakly-not-taken on reset, one entry trained per branch
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht[i] <= CTR_WNT;
            end
        end else if (resolve) begin
            bht[upd_idx] <= ctr_next(bht[upd_idx], cond_true);
        end
    end

    // Saturating statistics counters for legal branches and their mispredicts
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (resolve) begin
            if (branch_count != {CNT_W{1'b1}}) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispred && (mispredict_count != {CNT_W{1'b1}})) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule
